// File: rtl/emd_sift_sched_pkg.sv
// Shared definitions for the EMD sifting scheduler.
//
// - FSM state encodings. These are plain localparam constants so that existing code
//   which compares against the raw state value keeps working.
// - Encodings for the delay-line source mux.
// - Default delay-line latency. The scheduler and the data delay-line instance both
//   take this value, so their latencies stay matched.
// - A start-configuration check shared by the scheduler.
package emd_sift_sched_pkg;

    // Latency of the shared sample delay line, in cycles.
    localparam int unsigned DELAY_DEFAULT = 30;

    // Width of iter_cfg and pass_idx.
    localparam int unsigned PASS_W = 4;

    // Scheduler states.
    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StLoad      = 3'd1;
    localparam logic [2:0] StLoadDrain = 3'd2;
    localparam logic [2:0] StSift      = 3'd3;
    localparam logic [2:0] StSiftDrain = 3'd4;
    localparam logic [2:0] StDone      = 3'd5;

    // Delay-line input mux select.
    localparam logic SRC_EXT = 1'b0;  // external Xin
    localparam logic SRC_BUF = 1'b1;  // frame buffer read data

    // A start request is legal only for 1..max_iter recirculation passes.
    function automatic logic iter_cfg_ok(input logic [PASS_W-1:0] cfg,
                                         input int unsigned       max_iter);
        return (cfg != '0) && (32'(cfg) <= max_iter);
    endfunction

endpackage

// File: rtl/emd_sift_sched_valid_token_pipe.sv
// Valid-token pipe that runs beside the data delay line.
//
// This is a Depth-deep, 1-bit shift register with no enable. A token pushed in
// cycle t comes out in cycle t+Depth. The module also keeps a count of how many
// tokens are still inside the pipe.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset; clears all tokens
//   tok_i          token entering the pipe this cycle
//   tok_o          token leaving the pipe this cycle
//   outstanding_o  number of 1 tokens currently held in the pipe
module emd_sift_sched_valid_token_pipe #(
    parameter int unsigned Depth = 30,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tok_i,
    output logic            tok_o,
    output logic [CntW-1:0] outstanding_o
);

    logic [Depth-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = tok_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // A token entering and one leaving in the same cycle leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (tok_i && !tok_o) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!tok_i && tok_o) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign tok_o         = sr_q[Depth-1];
    assign outstanding_o = cnt_q;

endmodule

// File: rtl/emd_sift_sched.sv
// EMD sifting-frame scheduler.
//
// The scheduler sequences one free-running delay line (DELAY cycles) through the
// passes of a sifting frame:
//   - Pass 0 (LOAD) streams FRAME_LEN external samples into the frame buffer.
//   - Passes 1..iter_n (SIFT) read the buffer back through the delay line and
//     write the results in place.
// A valid-token pipe follows the data through the delay line. The scheduler uses
// it to produce the write strobe and write address, and to find the end of each
// pass.
//
// A write to address a always comes DELAY+1 cycles after the read of address a.
// FRAME_LEN must be greater than DELAY+1 so that the boundary between passes is
// also free of read/write hazards.
//
// Ports:
//   CLK, RST_N   clock (rising edge); asynchronous active-low reset
//   start        frame start pulse, honoured only in IDLE
//   iter_cfg     number of recirculation passes, latched on an accepted start
//   in_valid     external sample valid
//   in_ready     scheduler accepts an external sample (LOAD only)
//   src_sel      delay-line input mux: SRC_EXT / SRC_BUF
//   rd_en        frame buffer read strobe; data is returned one cycle later
//   rd_addr      frame buffer read address
//   dly_valid    delay-line output sample is valid
//   wr_en        frame buffer write strobe (same as dly_valid)
//   wr_addr      frame buffer write address
//   pass_idx     current pass: 0 = load, 1..iter_n = recirculation
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse when the frame completes
//   cfg_err      one-cycle pulse after a start is rejected
module emd_sift_sched
    import emd_sift_sched_pkg::*;
#(
    parameter int unsigned DELAY     = DELAY_DEFAULT,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned MAX_ITER  = 8,
    parameter int unsigned AW        = $clog2(FRAME_LEN)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [PASS_W-1:0] iter_cfg,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              src_sel,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    output logic              dly_valid,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    // Counters carry one extra bit so that the FRAME_LEN terminal count can be seen.
    localparam int unsigned   CW       = AW + 1;
    localparam int unsigned   TokCntW  = $clog2(DELAY + 1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW-1:0] LastIdx  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FrameLen = CW'(FRAME_LEN);

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      issue_q, issue_d;    // handshakes (LOAD) or reads (SIFT) this pass
    logic [CW-1:0]      wr_cnt_q, wr_cnt_d;  // writes this pass; low bits are wr_addr
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [PASS_W-1:0]  iter_q, iter_d;
    logic               cfg_err_q, cfg_err_d;
    logic               rd_en_q;

    logic               handshake;
    logic               tok_in;
    logic               tok_out;
    logic               drain_done;
    logic [TokCntW-1:0] outstanding;

    assign handshake = in_valid && in_ready;

    // The buffer has one cycle of read latency, so a read token enters the pipe one
    // cycle after its rd_en.
    assign tok_in = handshake || rd_en_q;

    emd_sift_sched_valid_token_pipe #(
        .Depth (DELAY),
        .CntW  (TokCntW)
    ) u_tok_pipe (
        .clk_i         (CLK),
        .rst_ni        (RST_N),
        .tok_i         (tok_in),
        .tok_o         (tok_out),
        .outstanding_o (outstanding)
    );

    // A pass is finished once every sample has been written back and the pipe is
    // empty.
    assign drain_done = (outstanding == '0) && (wr_cnt_q == FrameLen);

    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        wr_cnt_d  = wr_cnt_q;
        pass_d    = pass_q;
        iter_d    = iter_q;
        cfg_err_d = 1'b0;

        if (tok_out) begin
            wr_cnt_d = wr_cnt_q + CntOne;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (iter_cfg_ok(iter_cfg, MAX_ITER)) begin
                        iter_d   = iter_cfg;
                        pass_d   = '0;
                        issue_d  = '0;
                        wr_cnt_d = '0;
                        state_d  = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (handshake) begin
                    issue_d = issue_q + CntOne;
                    if (issue_q == LastIdx) begin
                        state_d = StLoadDrain;
                    end
                end
            end
            StLoadDrain: begin
                if (drain_done) begin
                    state_d  = StSift;
                    pass_d   = PASS_W'(1);
                    issue_d  = '0;
                    wr_cnt_d = '0;
                end
            end
            StSift: begin
                issue_d = issue_q + CntOne;
                if (issue_q == LastIdx) begin
                    state_d = StSiftDrain;
                end
            end
            StSiftDrain: begin
                if (drain_done) begin
                    if (pass_q < iter_q) begin
                        state_d  = StSift;
                        pass_d   = pass_q + PASS_W'(1);
                        issue_d  = '0;
                        wr_cnt_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d  = StIdle;
                pass_d   = '0;
                issue_d  = '0;
                wr_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            issue_q   <= '0;
            wr_cnt_q  <= '0;
            pass_q    <= '0;
            iter_q    <= '0;
            cfg_err_q <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            wr_cnt_q  <= wr_cnt_d;
            pass_q    <= pass_d;
            iter_q    <= iter_d;
            cfg_err_q <= cfg_err_d;
            rd_en_q   <= rd_en;
        end
    end

    assign in_ready   = (state_q == StLoad);
    assign rd_en      = (state_q == StSift);
    assign rd_addr    = rd_en ? issue_q[AW-1:0] : '0;

    // The last read of a pass returns its data during the first drain cycle, so the
    // mux has to stay on the buffer through SIFT_DRAIN.
    assign src_sel    = ((state_q == StSift) || (state_q == StSiftDrain)) ? SRC_BUF : SRC_EXT;

    assign dly_valid  = tok_out;
    assign wr_en      = tok_out;
    assign wr_addr    = wr_cnt_q[AW-1:0];
    assign pass_idx   = pass_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign cfg_err    = cfg_err_q;

endmodule

// File: doc/emd_sift_sched.md
Name: emd_sift_sched

Overview:
- Sequences one shared fixed-latency sample delay line (16-bit signed, DELAY cycles, free-running shift, no enable) through the passes of an EMD sifting frame.
- Pass 0 loads FRAME_LEN external samples through the delay line into a frame buffer.
- Passes 1..N re-circulate the buffer through the same delay line, writing results back in place.
- Tracks sample validity alongside the data and generates buffer addresses, source select, write strobes and frame completion.

Parameters:
- DELAY, 30, latency in cycles of the controlled delay line; the valid-token shift register has exactly this depth.
- FRAME_LEN, 256, samples per frame; must be > DELAY+1.
- MAX_ITER, 8, maximum number of recirculation passes.
- AW, $clog2(FRAME_LEN), frame buffer address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- iter_cfg  in  4  recirculation pass count, latched on accepted start.
- in_valid  in  1  external sample valid.
- in_ready  out  1  scheduler accepts an external sample.
- src_sel  out  1  delay-line input mux: 0 = external Xin, 1 = frame buffer read data.
- rd_en  out  1  frame buffer read strobe; read data is valid one cycle later.
- rd_addr  out  AW  frame buffer read address.
- dly_valid  out  1  delay-line output sample is valid this cycle.
- wr_en  out  1  frame buffer write strobe; equals dly_valid.
- wr_addr  out  AW  frame buffer write address.
- pass_idx  out  4  current pass: 0 = load, 1..N = recirculation.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async, RST_N=0): state IDLE. All outputs 0. Counters and addresses 0. Valid-token shift register cleared. Reset may assert in any state; the current frame is abandoned and there is no partial-frame completion.
- States: IDLE, LOAD, LOAD_DRAIN, SIFT, SIFT_DRAIN, DONE.
- IDLE:
  - start=1 with iter_cfg in 1..MAX_ITER: latch iter_n, pass_idx=0, go to LOAD.
  - start=1 with iter_cfg=0 or iter_cfg>MAX_ITER: cfg_err=1 for one cycle, stay in IDLE.
- LOAD:
  - in_ready=1 and src_sel=0.
  - Each in_valid&in_ready cycle pushes a 1 token into the valid shift register and increments issue_cnt. Cycles without a handshake push a 0 token.
  - When issue_cnt reaches FRAME_LEN, in_ready drops on the next cycle and the state moves to LOAD_DRAIN.
- LOAD_DRAIN / SIFT_DRAIN:
  - No new issues; tokens shift out.
  - Exit when the outstanding-token count is 0 and write count = FRAME_LEN.
  - From LOAD_DRAIN go to SIFT with pass_idx=1.
  - From SIFT_DRAIN go to SIFT with pass_idx+1 if pass_idx<iter_n, else to DONE.
- SIFT:
  - src_sel=1. rd_en=1 for FRAME_LEN consecutive cycles, rd_addr 0..FRAME_LEN-1.
  - The token for read k enters the shift register one cycle after its rd_en (buffer read latency).
  - Then go to SIFT_DRAIN.
- Output side:
  - dly_valid = token leaving the shift register.
  - A sample issued at cycle t (LOAD) appears at t+DELAY. A read at cycle t (SIFT) appears at t+1+DELAY.
  - Each dly_valid increments wr_addr; wr_addr resets to 0 at the start of each pass.
- In-place hazard: a write to address a always follows the read of address a by DELAY+1 cycles, so no read-after-write conflict within a pass. FRAME_LEN>DELAY+1 guarantees the pass boundary is safe.
- DONE: frame_done=1 for one cycle, then IDLE.
- start while busy is ignored; no error pulse.
- in_valid while in_ready=0 is ignored and never counted.
- Address counters wrap from FRAME_LEN-1 to 0. Counters are AW+1 bits wide to detect the FRAME_LEN terminal count.
- pass_idx saturates at iter_n; it never wraps.

Decomposition:
- Shared package: state enum, SRC_EXT/SRC_BUF encodings, DELAY default (30) so it matches the delay-line instance.
- One natural sub-module: valid_token_pipe (DELAY-deep 1-bit shift register plus outstanding-token counter), instanced beside the data delay line.

Test Plan:
- Reset mid-SIFT (pass 2, rd_addr=100) -> next cycle all outputs 0, state IDLE; a new start behaves as from power-up.
- start, iter_cfg=1, FRAME_LEN=256, in_valid held high -> first dly_valid 30 cycles after the first handshake; 256 wr_en in pass 0 and 256 in pass 1; frame_done exactly once, busy then low.
- LOAD with in_valid toggling 1,0,1,0 -> exactly 256 handshakes; dly_valid pattern equals the in_valid pattern delayed 30 cycles; wr_addr has no gaps.
- iter_cfg=0 and iter_cfg=9 -> cfg_err one-cycle pulse each, busy stays 0.
- iter_cfg=3 -> pass_idx sequence 0,1,2,3. In each SIFT pass the first wr_en comes 31 cycles after the first rd_en, and every write address is ≤ the read address of the same pass.
- start pulsed during LOAD -> ignored; iter_n and counters unchanged.
